reg_write_port: RTL and testbench
=================================

Name: reg_write_port

Overview:
- Write side of the 32-entry, 32-bit integer register bank.
- Accepts write-back requests over a valid/ready handshake and decodes the 5-bit destination to one-hot load enables.
- Holds the 32 registers and presents them as a flat bus to the 32x1 read multiplexers.
- Supports single-word writes and SPARC double-word (LDD-style) even/odd pair writes via a small state machine; r0 reads as zero.

Parameters:
- WIDTH, 32, register width in bits.
- NREGS, 32, number of registers; address width is log2(NREGS) = 5.

Ports:
- Clk  input  1  rising-edge clock.
- Clr  input  1  asynchronous active-low reset.
- WrValid  input  1  write request present.
- WrReady  output  1  port can accept a request this cycle.
- Rd  input  5  destination register number.
- DW  input  1  1 = double-word pair write, 0 = single word.
- DinHi  input  WIDTH  data for Rd (single) or the even register (pair).
- DinLo  input  WIDTH  data for the odd register (pair only; ignored when DW=0).
- E  output  NREGS  one-hot load-enable vector asserted in the cycle a register is written.
- Q  output  NREGS*WIDTH  register contents; register i on Q[WIDTH*i+WIDTH-1 : WIDTH*i].
- Busy  output  1  pair write in progress.
- AlignErr  output  1  one-cycle pulse: DW request with odd Rd.

Behaviour:
- Reset (Clr=0, async):
  - All registers, E, Busy and AlignErr go to 0; the FSM goes to IDLE.
  - WrReady is 0 while Clr=0 and goes to 1 on the first clock edge after Clr deasserts.
- Handshake:
  - A request is accepted on a rising edge with WrValid=1 and WrReady=1.
  - Rd, DW, DinHi and DinLo are sampled at acceptance only; later changes have no effect.
- FSM states: IDLE, PAIR_LO.
- IDLE, accept with DW=0:
  - DinHi is written to register Rd at that edge.
  - E is one-hot at bit Rd for the following cycle.
  - Stay in IDLE; WrReady stays 1, so back-to-back single writes run at one per cycle.
- IDLE, accept with DW=1:
  - Even address = {Rd[4:1],0}. DinHi is written to the even register at the accepting edge.
  - DinLo is latched into an internal hold register.
  - Go to PAIR_LO; WrReady=0 and Busy=1 for one cycle.
- PAIR_LO:
  - The held DinLo is written to even address + 1 at the next edge; E is one-hot on that register.
  - Return to IDLE; WrReady=1 and Busy=0.
  - WrValid is ignored in PAIR_LO.
- AlignErr:
  - Pulses high for the one cycle after accepting DW=1 with Rd[0]=1.
  - The write still proceeds with Rd[0] forced to 0.
- r0:
  - A write to register 0 is discarded and Q slice 0 always reads 0.
  - E[0] still pulses, so decode remains observable.
  - In a pair write to r0/r1, only r1 is updated.
- E timing:
  - E is registered: it reflects the write performed at the previous edge.
  - E is all-zero in any cycle with no write.
- Q timing:
  - Q is registered state with no bypass.
  - A write at edge k is visible on Q after edge k, i.e. in the same cycle E shows it.
- Reset mid-pair (Clr asserted in PAIR_LO):
  - The low half is abandoned; all registers clear.
  - The FSM returns to IDLE. No partial write survives.
- Width rule: data is stored unmodified. No sign extension; signed interpretation is left to the consumer.

Test Plan:
- Reset then idle:
  - Stimulus: hold Clr=0, then release.
  - Required: Q all 0, E=0, WrReady=0 while Clr=0, WrReady=1 one edge after release.
- Single writes:
  - Stimulus: Rd=i, DinHi=i for i=1..31, one per cycle, WrValid held.
  - Required: WrReady stays 1, E=1<<i the cycle after each accept, final Q slice i = i, slice 0 = 0.
- r0 write:
  - Stimulus: Rd=0, DinHi=32'hDEADBEEF.
  - Required: E=32'h1, Q slice 0 remains 0.
- Pair write:
  - Stimulus: DW=1, Rd=8, DinHi=32'h11111111, DinLo=32'h22222222, WrValid held.
  - Required: r8=32'h11111111 at the first edge, WrReady=0 and Busy=1 for one cycle, r9=32'h22222222 at the next edge, E=1<<8 then 1<<9.
- Misaligned pair:
  - Stimulus: DW=1, Rd=5, DinHi=-1, DinLo=7.
  - Required: AlignErr pulses one cycle, r4=32'hFFFFFFFF, r5=7.
- Reset mid-pair:
  - Stimulus: pair to Rd=2, then assert Clr in the PAIR_LO cycle.
  - Required: r2=r3=0 immediately, Busy=0, FSM in IDLE, next single write accepted normally.

Source files
------------

// File: rtl/reg_write_port_if.sv
// Write-request channel of the integer register bank: valid/ready handshake
// carrying the destination, pair flag and both data words.
interface reg_write_port_if #(
  parameter int WIDTH = 32,
  parameter int AW    = 5
);
  logic             WrValid;
  logic             WrReady;
  logic [AW-1:0]    Rd;
  logic             DW;
  logic [WIDTH-1:0] DinHi;
  logic [WIDTH-1:0] DinLo;

  modport master (output WrValid, Rd, DW, DinHi, DinLo, input WrReady);
  modport slave  (input WrValid, Rd, DW, DinHi, DinLo, output WrReady);
endinterface

// File: rtl/reg_write_port.sv
// Write side of the register bank: decodes write-back requests to one-hot load
// enables, holds the registers and sequences even/odd pair writes.
module reg_write_port_cell #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Clr,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] q_q, q_d;

  always_comb q_d = we ? d : q_q;

  always_ff @(posedge Clk or negedge Clr)
    if (!Clr) q_q <= '0;
    else      q_q <= q_d;

  assign q = q_q;
endmodule

module reg_write_port #(
  parameter int WIDTH = 32,
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic                   Clk,
  input  logic                   Clr,
  reg_write_port_if.slave        w,
  output logic [NREGS-1:0]       E,
  output logic [NREGS*WIDTH-1:0] Q,
  output logic                   Busy,
  output logic                   AlignErr
);
  typedef enum logic {IDLE, PAIR_LO} state_e;

  state_e           state_q, state_d;
  logic             ready_q, ready_d;
  logic             align_q, align_d;
  logic [NREGS-1:0] e_q, e_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [AW-1:0]    lo_q, lo_d;
  logic [AW-1:0]    ev;
  logic [WIDTH-1:0] wr_data;
  logic [NREGS-1:0][WIDTH-1:0] regs;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    lo_d    = lo_q;
    align_d = 1'b0;
    e_d     = '0;
    wr_data = '0;
    ev      = {w.Rd[AW-1:1], 1'b0};
    case (state_q)
      IDLE: begin
        if (w.WrValid && ready_q) begin
          wr_data = w.DinHi;
          if (w.DW) begin
            // Odd Rd on a pair is flagged but still written to the aligned pair.
            e_d[ev] = 1'b1;
            hold_d  = w.DinLo;
            lo_d    = {w.Rd[AW-1:1], 1'b1};
            align_d = w.Rd[0];
            state_d = PAIR_LO;
          end else begin
            e_d[w.Rd] = 1'b1;
          end
        end
      end
      PAIR_LO: begin
        wr_data  = hold_q;
        e_d[lo_q] = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge Clk or negedge Clr)
    if (!Clr) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      align_q <= 1'b0;
      e_q     <= '0;
      hold_q  <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      align_q <= align_d;
      e_q     <= e_d;
      hold_q  <= hold_d;
      lo_q    <= lo_d;
    end

  // The next-cycle enable doubles as the register load strobe; r0 is hardwired.
  for (genvar i = 0; i < NREGS; i++) begin : g_reg
    if (i == 0) begin : g_zero
      assign regs[i] = '0;
    end else begin : g_cell
      reg_write_port_cell #(.WIDTH(WIDTH)) u_cell (
        .Clk (Clk),
        .Clr (Clr),
        .we  (e_d[i]),
        .d   (wr_data),
        .q   (regs[i])
      );
    end
  end

  assign Q         = regs;
  assign E         = e_q;
  assign Busy      = (state_q == PAIR_LO);
  assign AlignErr  = align_q;
  assign w.WrReady = ready_q;
endmodule

// File: tb/tb_reg_write_port.sv
// Randomized and directed bench for reg_write_port against a transaction-level
// model of the register file.
module tb_reg_write_port;
  localparam int WIDTH = 32;
  localparam int NREGS = 32;
  localparam int QW    = NREGS * WIDTH;

  logic Clk = 1'b0;
  logic Clr = 1'b0;
  logic [NREGS-1:0] E;
  logic [QW-1:0]    Q;
  logic Busy, AlignErr;

  reg_write_port_if #(.WIDTH(WIDTH), .AW(5)) wif ();

  reg_write_port #(.WIDTH(WIDTH), .NREGS(NREGS)) dut (
    .Clk(Clk), .Clr(Clr), .w(wif.slave),
    .E(E), .Q(Q), .Busy(Busy), .AlignErr(AlignErr)
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;

  // reference state
  logic [WIDTH-1:0] m [NREGS];
  bit               m_rdy, m_pend, m_busy, m_align;
  int               m_lo_addr;
  logic [WIDTH-1:0] m_lo_data;
  logic [NREGS-1:0] m_e;

  task automatic chk(input string tag, input logic [QW-1:0] got, input logic [QW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [QW-1:0] exp_q();
    logic [QW-1:0] v;
    for (int i = 0; i < NREGS; i++) v[i*WIDTH +: WIDTH] = m[i];
    return v;
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < NREGS; i++) m[i] = '0;
    m_rdy = 0; m_pend = 0; m_busy = 0; m_align = 0; m_e = '0;
  endfunction

  function automatic void m_write(int a, logic [WIDTH-1:0] d);
    if (a != 0) m[a] = d;
    m_e = m_e | (NREGS'(1) << a);
  endfunction

  // One clock edge of the model, given the request seen before the edge.
  function automatic void m_edge(bit v, int rd, bit dw, logic [WIDTH-1:0] hi, logic [WIDTH-1:0] lo);
    bit accept;
    accept  = v && m_rdy && !m_pend;
    m_e     = '0;
    m_align = 0;
    if (m_pend) begin
      m_write(m_lo_addr, m_lo_data);
      m_pend = 0;
    end else if (accept) begin
      if (dw) begin
        m_write(rd - (rd % 2), hi);
        m_lo_addr = rd - (rd % 2) + 1;
        m_lo_data = lo;
        m_pend    = 1;
        m_align   = (rd % 2) == 1;
      end else begin
        m_write(rd, hi);
      end
    end
    m_rdy  = !m_pend;
    m_busy = m_pend;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".q"},     Q, exp_q());
    chk({tag, ".e"},     QW'(E), QW'(m_e));
    chk({tag, ".rdy"},   QW'(wif.WrReady), QW'(m_rdy));
    chk({tag, ".busy"},  QW'(Busy), QW'(m_busy));
    chk({tag, ".align"}, QW'(AlignErr), QW'(m_align));
  endtask

  // Drive a request, clock it, advance the model and check 1 ns after the edge.
  task automatic step(input string tag, input bit v, input int rd, input bit dw,
                      input logic [WIDTH-1:0] hi, input logic [WIDTH-1:0] lo);
    wif.WrValid = v;
    wif.Rd      = 5'(rd);
    wif.DW      = dw;
    wif.DinHi   = hi;
    wif.DinLo   = lo;
    @(posedge Clk);
    m_edge(v, rd, dw, hi, lo);
    #1;
    check_all(tag);
  endtask

  initial begin
    wif.WrValid = 0; wif.Rd = '0; wif.DW = 0; wif.DinHi = '0; wif.DinLo = '0;
    m_reset();

    // reset held across edges
    repeat (3) @(posedge Clk);
    #1;
    check_all("rst");
    Clr = 1'b1;
    step("rst_rel", 0, 0, 0, '0, '0);
    chk("rst_rel.rdy1", QW'(wif.WrReady), QW'(1'b1));

    // back-to-back singles
    for (int i = 1; i < NREGS; i++) begin
      step("single", 1, i, 0, WIDTH'(i), 32'hBAD0BAD0);
      chk("single.onehot", QW'(E), QW'(NREGS'(1) << i));
    end
    for (int i = 0; i < NREGS; i++)
      chk("single.slice", QW'(Q[i*WIDTH +: WIDTH]), QW'(i));

    // r0 discard
    step("r0", 1, 0, 0, 32'hDEADBEEF, '0);
    chk("r0.e", QW'(E), QW'(32'h1));
    chk("r0.q0", QW'(Q[WIDTH-1:0]), '0);

    // pair; WrValid held with different data must be ignored in PAIR_LO
    step("pair1", 1, 8, 1, 32'h11111111, 32'h22222222);
    chk("pair1.r8", QW'(Q[8*WIDTH +: WIDTH]), QW'(32'h11111111));
    chk("pair1.busy", QW'(Busy), QW'(1'b1));
    step("pair2", 1, 12, 0, 32'h33333333, 32'h44444444);
    chk("pair2.r9", QW'(Q[9*WIDTH +: WIDTH]), QW'(32'h22222222));
    chk("pair2.e", QW'(E), QW'(32'h200));
    chk("pair2.r12", QW'(Q[12*WIDTH +: WIDTH]), QW'(32'd12));

    // misaligned pair
    step("mis1", 1, 5, 1, 32'hFFFFFFFF, 32'd7);
    chk("mis1.align", QW'(AlignErr), QW'(1'b1));
    step("mis2", 0, 0, 0, '0, '0);
    chk("mis2.r4", QW'(Q[4*WIDTH +: WIDTH]), QW'(32'hFFFFFFFF));
    chk("mis2.r5", QW'(Q[5*WIDTH +: WIDTH]), QW'(32'd7));
    chk("mis2.align", QW'(AlignErr), QW'(1'b0));

    // pair to r0/r1: only r1 lands
    step("p01a", 1, 0, 1, 32'hAAAA5555, 32'h0F0F0F0F);
    step("p01b", 0, 0, 0, '0, '0);

    // reset in the PAIR_LO cycle
    step("midp", 1, 2, 1, 32'h12345678, 32'h9ABCDEF0);
    Clr = 1'b0;
    #1;
    m_reset();
    check_all("midp.rst");
    chk("midp.r2", QW'(Q[2*WIDTH +: WIDTH]), '0);
    chk("midp.r3", QW'(Q[3*WIDTH +: WIDTH]), '0);
    @(posedge Clk);
    #1;
    Clr = 1'b1;
    step("midp.rel", 0, 0, 0, '0, '0);
    step("midp.wr", 1, 3, 0, 32'hCAFEF00D, '0);
    step("midp.idle", 0, 0, 0, '0, '0);
    chk("midp.r3w", QW'(Q[3*WIDTH +: WIDTH]), QW'(32'hCAFEF00D));

    // random traffic
    for (int n = 0; n < 400; n++)
      step("rnd", bit'($urandom_range(0, 3) != 0), int'($urandom_range(0, NREGS-1)),
           bit'($urandom_range(0, 2) == 0), $urandom, $urandom);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
